// File: rtl/routex_sink_pkg.sv
// Shared definitions for the routex packet sink.
//   - sink FSM state encoding
//   - error codes reported on ERR_CODE
//   - header field bit positions
//   - expected payload pattern for flit index k
package routex_sink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DONE_ST = 2'd2
  } sink_state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_DEST      = 3'd1;
  localparam logic [2:0] ERR_DATA      = 3'd2;
  localparam logic [2:0] ERR_LEN_SHORT = 3'd3;
  localparam logic [2:0] ERR_LEN_LONG  = 3'd4;

  localparam int HDR_DEST_MSB = 63;
  localparam int HDR_DEST_LSB = 56;
  localparam int HDR_LEN_MSB  = 55;
  localparam int HDR_LEN_LSB  = 0;
  localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Payload flit k carries its own index in the low word.
  function automatic logic [63:0] payload_pattern(input logic [31:0] k);
    return {8'h00, 24'h0, k};
  endfunction

endpackage

// File: rtl/routex_pkt_sink.sv
// routex_pkt_sink: consumes header + payload packets, checks destination,
// length and payload pattern, and keeps good/bad/flit statistics.
//
// Ports
//   CLK       in   clock, rising edge
//   RST_N     in   synchronous active-low reset
//   DATA      in   64-bit flit
//   VALID     in   DATA holds a flit
//   LAST      in   final flit of a packet (with VALID)
//   BP        in   backpressure request, blocks transfers the same cycle
//   READY     out  flit accepted this cycle when VALID is also high
//   PKT_CNT   out  good packet count
//   ERR_CNT   out  bad packet count
//   FLIT_CNT  out  accepted flit count, headers included
//   DONE      out  one-cycle pulse after a packet's last flit
//   ERR       out  sticky error flag
//   ERR_CODE  out  most recent error code
//   LAST_LEN  out  payload flit count of the most recent packet
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a header flit
// PAYLOAD | counting payload flits, comparing until first error
// DONE_ST | one cycle, READY low, DONE high
module routex_pkt_sink #(
  parameter logic [7:0] MyAddr   = 8'h01,
  parameter int         CntWidth = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [63:0]         DATA,
  input  logic                VALID,
  input  logic                LAST,
  input  logic                BP,
  output logic                READY,
  output logic [CntWidth-1:0] PKT_CNT,
  output logic [CntWidth-1:0] ERR_CNT,
  output logic [63:0]         FLIT_CNT,
  output logic                DONE,
  output logic                ERR,
  output logic [2:0]          ERR_CODE,
  output logic [55:0]         LAST_LEN
);
  import routex_sink_pkg::*;

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  sink_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] k_q;
  logic             pkt_err_q;

  logic             xfer;
  logic [7:0]       hdr_dest;
  logic [LEN_W-1:0] hdr_len;
  logic [2:0]       det_code;
  logic             new_err;
  logic             pkt_bad;
  logic [LEN_W-1:0] k_next;

  // READY ignores VALID so an upstream source can wait on it safely.
  assign READY = RST_N && !BP && (state != DONE_ST);
  assign xfer  = VALID && READY;
  assign DONE  = (state == DONE_ST);

  assign hdr_dest = DATA[HDR_DEST_MSB:HDR_DEST_LSB];
  assign hdr_len  = DATA[HDR_LEN_MSB:HDR_LEN_LSB];
  assign k_next   = k_q + {{(LEN_W-1){1'b0}}, 1'b1};

  // Only the first error of a packet is reported; after that the packet
  // is drained without comparing.
  always_comb begin
    det_code = ERR_NONE;
    case (state)
      IDLE: begin
        if (hdr_dest != MyAddr)
          det_code = ERR_DEST;
        else if (LAST && (hdr_len != '0))
          det_code = ERR_LEN_SHORT;
      end
      PAYLOAD: begin
        if (!pkt_err_q) begin
          if (k_q >= len_q)
            det_code = ERR_LEN_LONG;
          else if (DATA != payload_pattern(k_q[31:0]))
            det_code = ERR_DATA;
          else if (LAST && ((len_q - k_q) > {{(LEN_W-1){1'b0}}, 1'b1}))
            det_code = ERR_LEN_SHORT;
        end
      end
      default: det_code = ERR_NONE;
    endcase
  end

  assign new_err = xfer && (det_code != ERR_NONE);
  assign pkt_bad = new_err || ((state == PAYLOAD) && pkt_err_q);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      len_q     <= '0;
      k_q       <= '0;
      pkt_err_q <= 1'b0;
      PKT_CNT   <= '0;
      ERR_CNT   <= '0;
      FLIT_CNT  <= '0;
      ERR       <= 1'b0;
      ERR_CODE  <= ERR_NONE;
      LAST_LEN  <= '0;
    end else begin
      if (xfer)
        FLIT_CNT <= FLIT_CNT + 64'd1;

      if (new_err) begin
        ERR      <= 1'b1;
        ERR_CODE <= det_code;
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            len_q     <= hdr_len;
            k_q       <= '0;
            pkt_err_q <= new_err;
            if (LAST) begin
              state    <= DONE_ST;
              LAST_LEN <= '0;
              if (pkt_bad) ERR_CNT <= ERR_CNT + CntOne;
              else         PKT_CNT <= PKT_CNT + CntOne;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            k_q <= k_next;
            if (new_err) pkt_err_q <= 1'b1;
            if (LAST) begin
              state    <= DONE_ST;
              LAST_LEN <= k_next;
              if (pkt_bad) ERR_CNT <= ERR_CNT + CntOne;
              else         PKT_CNT <= PKT_CNT + CntOne;
            end
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
